count_watch: RTL and testbench

Downstream monitor for the 4-bit up-counter: samples the counter's `q` output each enabled clock and checks that it advances legally. It reports wrap-around events and keeps a saturating wrap tally. It flags the first illegal transition with a sticky error and captures the offending value. It sits beside the counter on the same clock and feeds the status/debug logic.

---
 rtl/count_watch.sv | 123 ++++++++++++
 tb/tb_count_watch.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/count_watch.sv
// count_watch: watches a free-running up-counter's output, reports wraps and
// flags the first illegal transition with a sticky error and captured value.
module count_watch #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [WIDTH-1:0]  q_in,
  input  logic              ack,
  output logic              primed,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              seq_err,
  output logic [WIDTH-1:0]  err_val
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]  Q_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  Q_ZERO   = {WIDTH{1'b0}};
  localparam logic [WRAP_W-1:0] CNT_MAX  = {WRAP_W{1'b1}};
  localparam logic [WRAP_W-1:0] CNT_ZERO = {WRAP_W{1'b0}};

  state_t            state, state_nx;
  logic [WIDTH-1:0]  prev, prev_nx;
  logic              primed_nx, wrap_pulse_nx, seq_err_nx;
  logic [WRAP_W-1:0] wrap_cnt_nx, cnt_base;
  logic [WIDTH-1:0]  err_val_nx;
  logic [WIDTH:0]    prev_p1;
  logic              is_max, is_hold, is_step, is_wrap, is_restart, is_illegal;

  // Classify the current sample against the previous one.
  always_comb begin
    prev_p1    = {1'b0, prev} + {{WIDTH{1'b0}}, 1'b1};
    is_max     = (prev == Q_MAX);
    is_hold    = (q_in == prev);
    is_step    = !is_max && ({1'b0, q_in} == prev_p1);
    is_wrap    = is_max && (q_in == Q_ZERO);
    is_restart = (q_in == Q_ZERO) && (prev != Q_ZERO) && !is_max;
    is_illegal = !(is_hold || is_step || is_wrap || is_restart);
  end

  // Next-state and next-output logic; ack clears first so a same-edge event overrides it.
  always_comb begin
    state_nx      = state;
    prev_nx       = prev;
    primed_nx     = primed;
    wrap_pulse_nx = 1'b0;
    wrap_cnt_nx   = wrap_cnt;
    seq_err_nx    = seq_err;
    err_val_nx    = err_val;
    cnt_base      = ack ? CNT_ZERO : wrap_cnt;

    if (ack) begin
      seq_err_nx  = 1'b0;
      err_val_nx  = Q_ZERO;
      wrap_cnt_nx = CNT_ZERO;
      if (state == ERR) begin
        state_nx = TRACK;
      end else begin
        state_nx = state;
      end
    end else begin
      state_nx = state;
    end

    if (en) begin
      case (state)
        IDLE: begin
          prev_nx   = q_in;
          primed_nx = 1'b1;
          state_nx  = TRACK;
        end
        TRACK, ERR: begin
          prev_nx = q_in;
          if (is_wrap) begin
            wrap_pulse_nx = 1'b1;
            wrap_cnt_nx   = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + WRAP_W'(1'b1);
          end else if (is_illegal && ((state == TRACK) || ack)) begin
            seq_err_nx = 1'b1;
            err_val_nx = q_in;
            state_nx   = ERR;
          end else begin
            wrap_pulse_nx = 1'b0;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end else begin
      wrap_pulse_nx = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      prev       <= Q_ZERO;
      primed     <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= CNT_ZERO;
      seq_err    <= 1'b0;
      err_val    <= Q_ZERO;
    end else begin
      state      <= state_nx;
      prev       <= prev_nx;
      primed     <= primed_nx;
      wrap_pulse <= wrap_pulse_nx;
      wrap_cnt   <= wrap_cnt_nx;
      seq_err    <= seq_err_nx;
      err_val    <= err_val_nx;
    end
  end

endmodule

// File: tb/tb_count_watch.sv
// Table-driven bench for count_watch plus hand sequences for saturation and async reset.
module tb_count_watch;

  logic       clk;
  logic       clr;
  logic       en;
  logic [3:0] q_in;
  logic       ack;
  logic       primed;
  logic       wrap_pulse;
  logic [7:0] wrap_cnt;
  logic       seq_err;
  logic [3:0] err_val;

  int total;
  int bad;

  typedef struct {
    logic       en;
    logic [3:0] q;
    logic       ack;
    logic       primed;
    logic       wp;
    logic [7:0] cnt;
    logic       err;
    logic [3:0] ev;
  } vec_t;

  vec_t vecs[$];

  count_watch #(.WIDTH(4), .WRAP_W(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .q_in       (q_in),
    .ack        (ack),
    .primed     (primed),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt),
    .seq_err    (seq_err),
    .err_val    (err_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic [3:0] q, input logic a, input logic p,
                     input logic wp, input logic [7:0] c, input logic er, input logic [3:0] ev);
    vec_t v;
    v.en = e; v.q = q; v.ack = a; v.primed = p; v.wp = wp; v.cnt = c; v.err = er; v.ev = ev;
    vecs.push_back(v);
  endtask

  task automatic step(input logic e, input logic [3:0] q, input logic a);
    en = e; q_in = q; ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic p, input logic wp, input logic [7:0] c,
                         input logic er, input logic [3:0] ev);
    chk({tag, ".primed"},     32'(primed),     32'(p));
    chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(wp));
    chk({tag, ".wrap_cnt"},   32'(wrap_cnt),   32'(c));
    chk({tag, ".seq_err"},    32'(seq_err),    32'(er));
    chk({tag, ".err_val"},    32'(err_val),    32'(ev));
  endtask

  initial begin
    int exp_cnt;
    total = 0;
    bad   = 0;
    clr = 1'b0; en = 1'b0; q_in = 4'd0; ack = 1'b0;
    #12;
    chk_all("reset", 1'b0, 1'b0, 8'd0, 1'b0, 4'd0);
    clr = 1'b1;
    step(1'b0, 4'd3, 1'b0);
    chk("idle_no_en.primed", 32'(primed), 32'd0);

    // Full count with one wrap
    add(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);
    for (int v = 1; v < 16; v++) add(1'b1, 4'(v), 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);
    add(1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 4'd0);
    add(1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 4'd0);
    // ack clears tally, then restart from 9 back to 0
    add(1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);
    for (int v = 3; v < 10; v++) add(1'b1, 4'(v), 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);
    add(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);
    add(1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);
    add(1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);
    // en low ignores a bogus value
    add(1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);
    // 3,4,7 is illegal; later values don't overwrite the capture
    add(1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);
    add(1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);
    add(1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 4'd7);
    add(1'b1, 4'd8, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 4'd7);
    add(1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 4'd7);
    // ack on a legal step re-arms
    add(1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);
    add(1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);
    add(1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 4'd9);
    add(1'b1, 4'd10, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 4'd9);
    // ack with illegal in ERR re-captures
    add(1'b1, 4'd13, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 4'd13);
    add(1'b1, 4'd14, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 4'd13);
    add(1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 4'd13);
    // ack with wrap
    add(1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 4'd0);
    add(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 4'd0);
    // ack with illegal in TRACK: error wins
    add(1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 4'd6);
    add(1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].q, vecs[i].ack);
      chk_all($sformatf("vec%0d", i), vecs[i].primed, vecs[i].wp, vecs[i].cnt,
              vecs[i].err, vecs[i].ev);
    end

    // 300 wraps: tally saturates, pulses keep firing
    exp_cnt = 0;
    for (int w = 0; w < 300; w++) begin
      for (int v = 1; v < 16; v++) begin
        step(1'b1, 4'(v), 1'b0);
        if (v == 1) chk($sformatf("sat%0d.pulse_low", w), 32'(wrap_pulse), 32'd0);
      end
      step(1'b1, 4'd0, 1'b0);
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      chk($sformatf("sat%0d.pulse", w), 32'(wrap_pulse), 32'd1);
      chk($sformatf("sat%0d.cnt", w), 32'(wrap_cnt), 32'(exp_cnt));
    end
    chk("sat.final_cnt", 32'(wrap_cnt), 32'd255);

    // Error then async reset mid-cycle at 12
    step(1'b1, 4'd5, 1'b0);
    chk_all("pre_rst_err", 1'b1, 1'b0, 8'd255, 1'b1, 4'd5);
    for (int v = 6; v < 13; v++) step(1'b1, 4'(v), 1'b0);
    #3;
    clr = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 8'd0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 1'b0, 1'b0, 8'd0, 1'b0, 4'd0);
    #2;
    clr = 1'b1;
    step(1'b1, 4'd5, 1'b0);
    chk_all("post_rst_ref", 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);
    step(1'b1, 4'd6, 1'b0);
    chk("post_rst_step.err", 32'(seq_err), 32'd0);
    step(1'b1, 4'd2, 1'b0);
    chk_all("post_rst_illegal", 1'b1, 1'b0, 8'd0, 1'b1, 4'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
